// File: rtl/switch_input_ctrl.sv
// Board input reader: synchronises switches and confirm button, debounces the
// button, snapshots the switches on each accepted press and serves CPU reads.
module switch_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switches,
  input  logic        comfirm_button,
  input  logic        io_read,
  input  logic [1:0]  io_addr,
  output logic [15:0] io_rdata,
  output logic        data_valid,
  output logic        overrun,
  output logic        press_pulse
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                btn_meta_q, btn_s_q;
  logic [15:0]         sw_meta_q, sw_s_q;
  logic [15:0]         data_q;
  logic                valid_q, overrun_q, pulse_q;
  logic [15:0]         rdata_q, rdata_d;
  logic                press_evt, held, data_rd;

  // Two-flop synchronisers; nothing else touches the raw board inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      btn_meta_q <= comfirm_button;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= switches;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter restarts on every debounce-state entry, so it never passes CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_q)              state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = HELD;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (btn_s_q)                state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    press_evt = (state_q == PRESS_WAIT) && btn_s_q && (cnt_q == CNT_LAST);
    held      = (state_q == HELD) || (state_q == REL_WAIT);
    data_rd   = io_read && (io_addr == 2'd0);
    rdata_d   = '0;
    if (io_read) begin
      case (io_addr)
        2'd0:    rdata_d = data_q;
        2'd1:    rdata_d = {13'b0, held, overrun_q, valid_q};
        2'd2:    rdata_d = sw_s_q;
        default: rdata_d = '0;
      endcase
    end
  end

  // A DATA read in the press cycle returns the old snapshot and wins over overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      pulse_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pulse_q <= press_evt;
      rdata_q <= rdata_d;
      if (press_evt) data_q <= sw_s_q;
      if (press_evt)    valid_q <= 1'b1;
      else if (data_rd) valid_q <= 1'b0;
      if (data_rd)                   overrun_q <= 1'b0;
      else if (press_evt && valid_q) overrun_q <= 1'b1;
    end
  end

  assign io_rdata    = rdata_q;
  assign data_valid  = valid_q;
  assign overrun     = overrun_q;
  assign press_pulse = pulse_q;

endmodule
